// File: rtl/mbx_ombx_rd_ctrl.sv
// Outbound mailbox read sequencer: fetches the response object DWORD by DWORD from SRAM
// and hands each word to the system read-data register. Optional: MBX_RD_WATCHDOG_EN.
module mbx_ombx_rd_ctrl #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned SizeWidth     = 11,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mbx_read_i,
    input  logic                 abort_i,
    input  logic [AddrWidth-1:0] mbx_base_i,
    input  logic [AddrWidth-1:0] mbx_limit_i,
    input  logic [SizeWidth-1:0] obj_size_i,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 mem_rerror_i,
    output logic [31:0]          sys_rdata_o,
    output logic                 sys_rdata_valid_o,
    input  logic                 sys_pop_i,
    output logic                 sys_read_all_o,
    output logic                 rd_error_o
);

    typedef enum logic [2:0] {StIdle, StFetch, StWaitRsp, StHold, StDone, StDrain} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] ptr_q, ptr_d;
    logic [SizeWidth-1:0] cnt_q, cnt_d;
    logic [SizeWidth-1:0] size_q, size_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 mbx_read_q;
    logic                 read_all_q, read_all_d;
    logic                 flush, start, overflow;

`ifdef MBX_RD_WATCHDOG_EN
    localparam int unsigned WdogWidth =
        ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;

    logic [WdogWidth-1:0] wdog_q, wdog_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    // A level-low mbx_read_i in an active state can only mean it fell after start.
    assign flush    = abort_i | ~mbx_read_i;
    assign start    = mbx_read_i & ~mbx_read_q & ~abort_i;
    assign overflow = ptr_q > mbx_limit_i;

    assign mem_addr_o        = ptr_q;
    assign sys_rdata_o       = rdata_q;
    assign sys_rdata_valid_o = (state_q == StHold);

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        size_d         = size_q;
        rdata_d        = rdata_q;
        read_all_d     = 1'b0;
        mem_req_o      = 1'b0;
        rd_error_o     = 1'b0;
        sys_read_all_o = read_all_q;
`ifdef MBX_RD_WATCHDOG_EN
        wdog_d         = '0;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d  = mbx_base_i;
                    cnt_d  = '0;
                    size_d = obj_size_i;
                    if (obj_size_i == '0) begin
                        read_all_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                mem_req_o = ~overflow;
                if (flush) begin
                    rdata_d = '0;
                    state_d = (mem_gnt_i && !overflow) ? StDrain : StIdle;
                end else if (overflow) begin
                    rd_error_o = 1'b1;
                    state_d    = StDone;
                end else if (mem_gnt_i) begin
                    state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (flush) begin
                    // A response landing in the abort cycle closes the transaction itself.
                    rdata_d = '0;
                    state_d = mem_rvalid_i ? StIdle : StDrain;
                end else if (mem_rvalid_i) begin
                    if (mem_rerror_i) begin
                        rd_error_o = 1'b1;
                        rdata_d    = '0;
                        state_d    = StDone;
                    end else begin
                        rdata_d = mem_rdata_i;
                        state_d = StHold;
                    end
                end
`ifdef MBX_RD_WATCHDOG_EN
                else if (wdog_q == WdogWidth'(TimeoutCycles - 1)) begin
                    rd_error_o = 1'b1;
                    state_d    = StDrain;
                end else begin
                    wdog_d = wdog_q + WdogWidth'(1);
                end
`endif
            end
            StHold: begin
                if (flush) begin
                    rdata_d = '0;
                    state_d = StIdle;
                end else if (sys_pop_i) begin
                    cnt_d = cnt_q + SizeWidth'(1);
                    if (cnt_d == size_q) begin
                        sys_read_all_o = 1'b1;
                        state_d        = StDone;
                    end else begin
                        ptr_d   = ptr_q + AddrWidth'(4);
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                if (flush) begin
                    rdata_d = '0;
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (mem_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            rdata_q    <= '0;
            mbx_read_q <= 1'b0;
            read_all_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            rdata_q    <= rdata_d;
            mbx_read_q <= mbx_read_i;
            read_all_q <= read_all_d;
        end
    end

endmodule

// File: tb/tb_mbx_ombx_rd_ctrl.sv
// Scoreboard bench for mbx_ombx_rd_ctrl: a behavioural SRAM responder, an auto-pop system
// model and a monitor that checks requests, data and pulses against queued expectations.
module tb_mbx_ombx_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        mbx_read_i, abort_i;
    logic [31:0] mbx_base_i, mbx_limit_i;
    logic [10:0] obj_size_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_rerror_i = 1'b0;
    logic [31:0] sys_rdata_o;
    logic        sys_rdata_valid_o;
    logic        sys_pop_i = 1'b0;
    logic        sys_read_all_o, rd_error_o;

    always #5 clk = ~clk;

    mbx_ombx_rd_ctrl #(
        .AddrWidth    (32),
        .SizeWidth    (11),
        .TimeoutCycles(16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .mbx_read_i       (mbx_read_i),
        .abort_i          (abort_i),
        .mbx_base_i       (mbx_base_i),
        .mbx_limit_i      (mbx_limit_i),
        .obj_size_i       (obj_size_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .mem_rerror_i     (mem_rerror_i),
        .sys_rdata_o      (sys_rdata_o),
        .sys_rdata_valid_o(sys_rdata_valid_o),
        .sys_pop_i        (sys_pop_i),
        .sys_read_all_o   (sys_read_all_o),
        .rd_error_o       (rd_error_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Stimulus knobs, written by the main thread only
    int          gnt_delay = 0;
    int          rsp_delay = 0;
    int          exp_lat = 3;
    bit          auto_pop = 1'b1;
    bit          force_pop = 1'b0;
    bit          rsp_hold = 1'b0;
    bit          force_dead = 1'b0;
    logic [31:0] err_addr = '1;
    int          start_cyc = 0;

    // Scoreboard queues
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [32:0] exp_ra[$];
    logic [1:0]  exp_err[$];

    // Responder / monitor state
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          rsp_wait = 0;
    int          gnt_wait = 0;
    int          gnt_cyc = 0;
    int          ra_cnt = 0, err_cnt = 0, ra_cyc = 0, err_cyc = 0;
    int          last_pop_cyc = 0, req_run = 0;
    bit          valid_prev = 1'b0, have_pop = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an unexpected event, expected none", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data word is 0xC0DE in the upper half and the low address bits below.
    always @(negedge clk) begin
        #1;
        mem_rvalid_i = 1'b0;
        mem_rerror_i = 1'b0;
        mem_rdata_i  = '0;
        if (pend && !rsp_hold) begin
            if (rsp_wait == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = force_dead ? 32'hDEAD_BEEF : {16'hC0DE, pend_addr[15:0]};
                mem_rerror_i = (pend_addr == err_addr);
                pend         = 1'b0;
            end else begin
                rsp_wait--;
            end
        end
        mem_gnt_i = 1'b0;
        if (mem_req_o) begin
            if (gnt_wait < gnt_delay) begin
                gnt_wait++;
            end else begin
                mem_gnt_i = 1'b1;
                gnt_wait  = 0;
                pend      = 1'b1;
                pend_addr = mem_addr_o;
                rsp_wait  = rsp_delay;
                gnt_cyc   = cyc;
            end
        end else begin
            gnt_wait = 0;
        end
    end

    always @(negedge clk) begin
        #1;
        sys_pop_i = (auto_pop && sys_rdata_valid_o) || force_pop;
    end

    always @(negedge clk) begin
        #3;
        if (rst_ni) begin
            if (mem_req_o) begin
                req_run++;
                if (exp_addr.size() == 0) begin
                    unexpected("mem_req");
                end else begin
                    check("mem_addr", mem_addr_o, exp_addr[0]);
                    if (mem_gnt_i) begin
                        check("req_held_cycles", req_run, gnt_delay + 1);
                        void'(exp_addr.pop_front());
                        req_run = 0;
                    end
                end
            end else begin
                req_run = 0;
            end
            if (sys_rdata_valid_o && !valid_prev) begin
                if (exp_data.size() == 0) unexpected("rdata_valid");
                else check("rdata", sys_rdata_o, exp_data.pop_front());
                if (have_pop && exp_lat != 0) check("pop_latency", cyc - last_pop_cyc, exp_lat);
            end
            if (sys_pop_i && sys_rdata_valid_o) begin
                have_pop     = 1'b1;
                last_pop_cyc = cyc;
            end
            if (!mbx_read_i) have_pop = 1'b0;
            if (sys_read_all_o) begin
                ra_cnt++;
                ra_cyc = cyc;
                if (exp_ra.size() == 0) unexpected("read_all");
                else check("read_all_pop_data", {sys_pop_i, sys_rdata_o}, exp_ra.pop_front());
            end
            if (rd_error_o) begin
                err_cnt++;
                err_cyc = cyc;
                if (exp_err.size() == 0) unexpected("rd_error");
                else check("rd_error_rsp", {mem_rvalid_i, mem_rerror_i}, exp_err.pop_front());
            end
            valid_prev = sys_rdata_valid_o;
        end
    end

    task automatic start_obj(input logic [31:0] base, input logic [10:0] size);
        @(negedge clk);
        mbx_base_i = base;
        obj_size_i = size;
        mbx_read_i = 1'b1;
        start_cyc  = cyc;
    endtask

    task automatic wait_evt(input int target, input string name);
        int n = 0;
        while ((ra_cnt + err_cnt) < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if ((ra_cnt + err_cnt) < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out with %0d events, expected %0d", name,
                     ra_cnt + err_cnt, target);
        end
    endtask

    task automatic end_obj(input string tag);
        @(negedge clk);
        mbx_read_i = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_addr_left"}, exp_addr.size(), 0);
        check({tag, "_data_left"}, exp_data.size(), 0);
        check({tag, "_read_all_left"}, exp_ra.size(), 0);
        check({tag, "_error_left"}, exp_err.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_ni      = 1'b0;
        mbx_read_i  = 1'b0;
        abort_i     = 1'b0;
        mbx_base_i  = '0;
        mbx_limit_i = 32'h0000_0FFC;
        obj_size_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_rdata", sys_rdata_o, 0);
        check("rst_rdata_valid", sys_rdata_valid_o, 0);
        check("rst_read_all", sys_read_all_o, 0);
        check("rst_rd_error", rd_error_o, 0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // Three words, zero-wait SRAM, immediate pops
        exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h104);
        exp_addr.push_back(32'h108);
        exp_data.push_back(32'hC0DE_0100);
        exp_data.push_back(32'hC0DE_0104);
        exp_data.push_back(32'hC0DE_0108);
        exp_ra.push_back({1'b1, 32'hC0DE_0108});
        start_obj(32'h100, 11'd3);
        wait_evt(1, "t1_read_all");
        end_obj("t1");
        check("t1_read_all_count", ra_cnt, 1);

        // Empty object
        exp_ra.push_back({1'b0, 32'h0});
        start_obj(32'h300, 11'd0);
        wait_evt(2, "t2_read_all");
        check("t2_read_all_cycle", ra_cyc - start_cyc, 1);
        end_obj("t2");

        // Grant delayed 5 cycles, stray pop during Fetch
        gnt_delay = 5;
        exp_lat   = 8;
        exp_addr.push_back(32'h200);
        exp_addr.push_back(32'h204);
        exp_data.push_back(32'hC0DE_0200);
        exp_data.push_back(32'hC0DE_0204);
        exp_ra.push_back({1'b1, 32'hC0DE_0204});
        start_obj(32'h200, 11'd2);
        @(negedge clk);
        force_pop = 1'b1;
        @(negedge clk);
        force_pop = 1'b0;
        wait_evt(3, "t3_read_all");
        end_obj("t3");
        gnt_delay = 0;
        exp_lat   = 3;

        // Abort in WaitRsp; response arrives two cycles later in Drain
        rsp_delay  = 2;
        force_dead = 1'b1;
        exp_addr.push_back(32'h400);
        start_obj(32'h400, 11'd2);
        repeat (2) @(negedge clk);
        abort_i    = 1'b1;
        mbx_read_i = 1'b0;
        @(negedge clk);
        abort_i = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_rdata_cleared", sys_rdata_o, 0);
        check("t4_rdata_valid", sys_rdata_valid_o, 0);
        check("t4_read_all_count", ra_cnt, 3);
        rsp_delay  = 0;
        force_dead = 1'b0;
        exp_addr.push_back(32'h400);
        exp_data.push_back(32'hC0DE_0400);
        exp_ra.push_back({1'b1, 32'hC0DE_0400});
        start_obj(32'h400, 11'd1);
        wait_evt(4, "t4_restart");
        end_obj("t4");

        // Response error on the second of four words
        err_addr = 32'h504;
        exp_addr.push_back(32'h500);
        exp_addr.push_back(32'h504);
        exp_data.push_back(32'hC0DE_0500);
        exp_err.push_back(2'b11);
        start_obj(32'h500, 11'd4);
        wait_evt(5, "t5_rd_error");
        @(negedge clk);
        check("t5_rdata_cleared", sys_rdata_o, 0);
        check("t5_rdata_valid", sys_rdata_valid_o, 0);
        end_obj("t5");
        check("t5_read_all_count", ra_cnt, 4);
        check("t5_error_count", err_cnt, 1);
        err_addr = '1;

        // Base beyond the mailbox limit
        exp_err.push_back(2'b00);
        start_obj(32'h1000, 11'd1);
        wait_evt(6, "t7_overflow");
        end_obj("t7");
        check("t7_read_all_count", ra_cnt, 4);

`ifdef MBX_RD_WATCHDOG_EN
        // Response withheld past the watchdog limit, then released late
        rsp_hold = 1'b1;
        exp_addr.push_back(32'h600);
        exp_err.push_back(2'b00);
        start_obj(32'h600, 11'd1);
        wait_evt(7, "t6_timeout");
        check("t6_timeout_cycle", err_cyc - gnt_cyc, 16);
        rsp_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_rdata_valid", sys_rdata_valid_o, 0);
        end_obj("t6");
        exp_addr.push_back(32'h604);
        exp_data.push_back(32'hC0DE_0604);
        exp_ra.push_back({1'b1, 32'hC0DE_0604});
        start_obj(32'h604, 11'd1);
        wait_evt(8, "t6_restart");
        end_obj("t6r");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbx_ombx_rd_ctrl.md
Name: mbx_ombx_rd_ctrl

Overview:
- Read sequencer for the outbound mailbox.
- While the mailbox control FSM is in its Read state, this block fetches the response object one DWORD at a time from mailbox SRAM over a req/gnt/rvalid host port.
- It presents each word to the system-side read-data register and advances on system pop.
- It pulses sys_read_all_o when the last word is consumed; the control FSM uses this pulse to return to Idle.

Parameters:
- AddrWidth, 32, SRAM byte address width.
- SizeWidth, 11, width of the object size in DWORDs (max 1024).
- TimeoutCycles, 255, response watchdog limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mbx_read_i  in  1  control FSM is in Read state (level)
- abort_i  in  1  error, abort or abort-ack from the control FSM; flushes the block
- mbx_base_i  in  AddrWidth  first byte address of the object, DWORD aligned
- mbx_limit_i  in  AddrWidth  last valid DWORD address of the mailbox range
- obj_size_i  in  SizeWidth  object length in DWORDs, sampled on start
- mem_req_o  out  1  SRAM read request
- mem_addr_o  out  AddrWidth  SRAM read address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read response valid
- mem_rdata_i  in  32  read data
- mem_rerror_i  in  1  response error
- sys_rdata_o  out  32  current read-data register value
- sys_rdata_valid_o  out  1  sys_rdata_o holds an unconsumed word
- sys_pop_i  in  1  system write to the read-data register; consume the word
- sys_read_all_o  out  1  one-cycle pulse: last word consumed
- rd_error_o  out  1  one-cycle pulse: response error, range overflow or timeout

Behaviour:
- Reset: state Idle; all outputs 0; sys_rdata_o = 0; pointer and count = 0.
- States: Idle, Fetch, WaitRsp, Hold, Done, Drain.
- Idle:
  - On a rising edge of mbx_read_i with abort_i = 0, latch ptr = mbx_base_i, cnt = 0, size = obj_size_i.
  - If size == 0: pulse sys_read_all_o the next cycle and go to Done.
  - Otherwise go to Fetch.
- Fetch:
  - mem_req_o = 1, mem_addr_o = ptr; both held stable until mem_gnt_i.
  - On mem_gnt_i go to WaitRsp.
  - If ptr > mbx_limit_i: no request is issued; pulse rd_error_o and go to Done.
- WaitRsp:
  - On mem_rvalid_i, latch sys_rdata_o = mem_rdata_i.
  - If mem_rerror_i: pulse rd_error_o, set sys_rdata_o = 0, go to Done.
  - Otherwise go to Hold.
- Hold:
  - sys_rdata_valid_o = 1.
  - On sys_pop_i: cnt = cnt + 1.
  - If the new cnt == size: pulse sys_read_all_o in the same cycle as the pop and go to Done.
  - Otherwise ptr = ptr + 4 and go to Fetch.
- Pop rules:
  - sys_pop_i outside Hold is ignored.
  - Pop-to-next-valid latency is at least 3 cycles (Fetch, WaitRsp, Hold) with zero-wait gnt/rvalid.
- Done: wait for mbx_read_i = 0, then go to Idle. sys_read_all_o is issued at most once per object.
- Abort (abort_i = 1, or mbx_read_i falling, in any state):
  - sys_rdata_valid_o drops and sys_rdata_o clears the next cycle.
  - No sys_read_all_o pulse.
  - If a request is outstanding (WaitRsp, or Fetch with gnt this cycle): go to Drain; otherwise go to Idle.
  - In Fetch without gnt, mem_req_o drops.
- Drain: discard the next mem_rvalid_i, then go to Idle. A new start is not accepted until Drain completes.
- Arithmetic:
  - ptr arithmetic is modulo 2^AddrWidth.
  - cnt is SizeWidth wide; cnt never exceeds size.
- Simultaneous events: abort_i has priority over sys_pop_i and mem_rvalid_i in the same cycle.

Optional Feature:
- Macro MBX_RD_WATCHDOG_EN.
- Defined:
  - An 8-bit+ counter runs while in WaitRsp.
  - If TimeoutCycles cycles elapse without mem_rvalid_i: pulse rd_error_o and go to Drain.
  - A late response is discarded in Drain.
- Undefined: no counter; WaitRsp waits indefinitely.

Test Plan:
1. base = 0x100, size = 3, zero-wait SRAM, pops as soon as valid. Expected:
   - addresses 0x100, 0x104, 0x108;
   - data matches;
   - sys_read_all_o pulses once, in the same cycle as the third pop.
2. size = 0, mbx_read_i rises. Expected: sys_read_all_o pulses the next cycle; no mem_req_o.
3. gnt delayed 5 cycles. Expected: mem_req_o/mem_addr_o held stable for 5 cycles; a pop during Fetch is ignored and cnt is unchanged.
4. abort_i asserted in WaitRsp, rvalid arrives 2 cycles later with 0xDEADBEEF. Expected:
   - data is discarded and sys_rdata_o stays 0;
   - no sys_read_all_o;
   - a restart after Drain begins fetching at mbx_base_i.
5. mem_rerror_i on word 2 of 4. Expected: rd_error_o pulses once; block reaches Done with no sys_read_all_o.
6. With MBX_RD_WATCHDOG_EN and TimeoutCycles = 16, rvalid withheld. Expected:
   - rd_error_o pulses at WaitRsp cycle 16;
   - a late rvalid is absorbed in Drain;
   - block returns to Idle.
